// File: rtl/battery_voltage_sampler_pkg.sv
// Shared constants, frame FSM encoding and bit-position helper for the
// battery voltage sampler and its SPI frame reader.
package battery_voltage_sampler_pkg;

  localparam int ADC_FRAME_BITS      = 16;
  localparam int ADC_DATA_FIRST_EDGE = 3;
  localparam int ADC_DATA_BITS       = 12;
  localparam int SCALE_SHIFT         = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } frame_state_t;

  // True for the SCLK rising-edge indices that carry code bits.
  function automatic logic is_data_edge(input logic [3:0] edge_idx);
    return (int'(edge_idx) >= ADC_DATA_FIRST_EDGE) &&
           (int'(edge_idx) <  ADC_DATA_FIRST_EDGE + ADC_DATA_BITS);
  endfunction

endpackage

// File: rtl/battery_voltage_sampler_adc_frame_reader.sv
// One 16-bit SPI mode-0 conversion frame per start pulse; returns the 12-bit
// code from the middle of the frame with a one-cycle code_valid pulse.
module adc_frame_reader
  import battery_voltage_sampler_pkg::*;
#(
  parameter int CLK_DIV = 6
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        start,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        busy,
  output logic [11:0] code,
  output logic        code_valid
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [3:0]    EDGE_LAST = 4'(ADC_FRAME_BITS - 1);

  frame_state_t  state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    edge_cnt;
  logic [11:0]   shreg;
  logic          miso_meta;
  logic          miso_sync;
  logic          div_done;

  assign div_done = (div_cnt == DIV_LAST);
  assign busy     = (state != IDLE);
  assign code     = shreg;

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= adc_miso;
      miso_sync <= miso_meta;
    end
  end

  // Each SCLK half lasts CLK_DIV cycles; bits are captured on the cycle SCLK rises.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      shreg      <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
          end
        end
        SETUP: begin
          if (div_done) begin
            state    <= SHIFT;
            div_cnt  <= '0;
            edge_cnt <= '0;
            adc_sclk <= 1'b1;
            if (is_data_edge(4'd0))
              shreg <= {shreg[10:0], miso_sync};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_done) begin
            div_cnt <= '0;
            if (adc_sclk) begin
              adc_sclk <= 1'b0;
            end else if (edge_cnt == EDGE_LAST) begin
              state      <= DONE;
              adc_cs_n   <= 1'b1;
              code_valid <= 1'b1;
            end else begin
              adc_sclk <= 1'b1;
              edge_cnt <= edge_cnt + 4'd1;
              if (is_data_edge(edge_cnt + 4'd1))
                shreg <= {shreg[10:0], miso_sync};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/battery_voltage_sampler.sv
// Periodic battery-sense sampler: starts ADC frames, averages 2^AVG_LOG2
// codes and scales the average to millivolts.
module battery_voltage_sampler
  import battery_voltage_sampler_pkg::*;
#(
  parameter int CLK_DIV       = 6,
  parameter int SAMPLE_PERIOD = 12000,
  parameter int AVG_LOG2      = 4,
  parameter int SCALE_MV      = 33000
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] battery_voltage,
  output logic        voltage_valid,
  output logic        new_value
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] COUNT_LAST  = CW'((1 << AVG_LOG2) - 1);

  logic [PW-1:0] period_cnt;
  logic          start_tick;
  logic          busy;
  logic [11:0]   code;
  logic          code_valid;
  logic [15:0]   acc;
  logic [15:0]   acc_sum;
  logic [CW-1:0] sample_cnt;
  logic [11:0]   avg;
  logic          avg_ready;
  logic [27:0]   product;

  assign start_tick = (period_cnt == PERIOD_LAST);

  adc_frame_reader #(
    .CLK_DIV(CLK_DIV)
  ) u_reader (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .start     (start_tick),
    .adc_miso  (adc_miso),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .busy      (busy),
    .code      (code),
    .code_valid(code_valid)
  );

  // Ticks that land while a frame is running are simply lost by the reader.
  always_ff @(posedge clk_12MHz) begin
    if (reset)
      period_cnt <= '0;
    else if (start_tick)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + 1'b1;
  end

  always_comb begin
    acc_sum = acc + 16'(code);
    product = 28'(avg) * 28'(SCALE_MV);
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      avg        <= '0;
      avg_ready  <= 1'b0;
    end else begin
      avg_ready <= 1'b0;
      if (code_valid) begin
        if (sample_cnt == COUNT_LAST) begin
          avg        <= 12'(acc_sum >> AVG_LOG2);
          avg_ready  <= 1'b1;
          acc        <= '0;
          sample_cnt <= '0;
        end else begin
          acc        <= acc_sum;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      battery_voltage <= '0;
      voltage_valid   <= 1'b0;
      new_value       <= 1'b0;
    end else begin
      new_value <= avg_ready;
      if (avg_ready) begin
        battery_voltage <= 16'(product >> SCALE_SHIFT);
        voltage_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_battery_voltage_sampler.sv
// Directed bench: one default-parameter sampler for frame shape and first tick,
// one fast-period sampler with an ADC model for averaging, scaling and reset cases.
module tb_battery_voltage_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_f;
  logic        d_miso, f_miso;
  logic        d_cs_n, d_sclk, d_valid, d_new;
  logic        f_cs_n, f_sclk, f_valid, f_new;
  logic [15:0] d_bv, f_bv;

  int checks = 0;
  int failures = 0;

  battery_voltage_sampler dut_default (
    .clk_12MHz      (clk),
    .reset          (rst_d),
    .adc_miso       (d_miso),
    .adc_cs_n       (d_cs_n),
    .adc_sclk       (d_sclk),
    .battery_voltage(d_bv),
    .voltage_valid  (d_valid),
    .new_value      (d_new)
  );

  battery_voltage_sampler #(
    .CLK_DIV      (6),
    .SAMPLE_PERIOD(100),
    .AVG_LOG2     (4),
    .SCALE_MV     (33000)
  ) dut_fast (
    .clk_12MHz      (clk),
    .reset          (rst_f),
    .adc_miso       (f_miso),
    .adc_cs_n       (f_cs_n),
    .adc_sclk       (f_sclk),
    .battery_voltage(f_bv),
    .voltage_valid  (f_valid),
    .new_value      (f_new)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // ADC model for the fast instance: frame word = {pre[2:0], code[11:0], post}.
  logic [11:0] f_code;
  logic [2:0]  f_pre;
  logic        f_post;
  bit          f_alt_mode;
  bit          f_alt;
  logic [15:0] f_word;
  int          f_bit;

  always @(negedge f_cs_n) begin
    logic [11:0] sel;
    if (f_alt_mode) begin
      sel   = f_alt ? 12'hFFF : 12'h000;
      f_alt = ~f_alt;
    end else begin
      sel = f_code;
    end
    f_word = {f_pre, sel, f_post};
    f_bit  = 15;
    #1 f_miso = f_word[15];
  end

  always @(negedge f_sclk) begin
    if (f_cs_n === 1'b0 && f_bit > 0) begin
      f_bit = f_bit - 1;
      #1 f_miso = f_word[f_bit];
    end
  end

  // Frame-shape monitor on the fast instance: half-periods, low time, pulses, start spacing.
  int  m_low, m_run, m_pulses, m_since_fall;
  logic m_prev_cs, m_prev_sclk;

  always @(negedge clk) begin
    if (rst_f) begin
      m_low = 0; m_run = 0; m_pulses = 0; m_since_fall = -1;
      m_prev_cs = 1'b1; m_prev_sclk = 1'b0;
    end else begin
      logic fall, rise;
      fall = m_prev_cs && !f_cs_n;
      rise = !m_prev_cs && f_cs_n;
      if (m_since_fall >= 0) m_since_fall++;
      if (fall) begin
        if (m_since_fall >= 0) checkOutput("fast_frame_start_spacing", 32'(m_since_fall), 200);
        m_since_fall = 0; m_low = 0; m_pulses = 0; m_run = 0;
      end
      if (!f_cs_n) begin
        m_low++;
        if (!fall && f_sclk !== m_prev_sclk) begin
          checkOutput("fast_sclk_half", 32'(m_run), 6);
          m_run = 0;
          if (f_sclk) m_pulses++;
        end
        m_run++;
      end
      if (rise) begin
        checkOutput("fast_last_low_half", 32'(m_run), 6);
        checkOutput("fast_cs_low_time", 32'(m_low), 198);
        checkOutput("fast_sclk_pulses", 32'(m_pulses), 16);
        checkOutput("fast_sclk_idle", 32'(f_sclk), 0);
      end
      m_prev_cs = f_cs_n;
      m_prev_sclk = f_sclk;
    end
  end

  task automatic applyStimulus(input logic [11:0] code, input bit alt,
                               input logic [2:0] pre, input logic post);
    @(negedge clk);
    rst_f = 1'b1;
    f_code = code; f_alt_mode = alt; f_alt = 1'b0; f_pre = pre; f_post = post;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
  endtask

  task automatic awaitResult(output int frames, output int lag,
                             output logic valid_before, output bit found);
    logic prev_cs, prev_valid;
    frames = 0; lag = 0; found = 0; valid_before = 1'bx;
    prev_cs = f_cs_n; prev_valid = f_valid;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!prev_cs && f_cs_n) begin
        frames++;
        lag = 0;
      end else begin
        lag++;
      end
      if (f_new) begin
        valid_before = prev_valid;
        found = 1;
        break;
      end
      prev_cs = f_cs_n;
      prev_valid = f_valid;
    end
  endtask

  task automatic runCase(input string tag, input logic [15:0] exp_bv);
    int frames, lag;
    logic vb;
    bit found;
    awaitResult(frames, lag, vb, found);
    checkOutput({tag, "_result_seen"}, 32'(found), 1);
    checkOutput({tag, "_frames"}, 32'(frames), 16);
    checkOutput({tag, "_latency"}, 32'(lag), 2);
    checkOutput({tag, "_valid_before"}, 32'(vb), 0);
    checkOutput({tag, "_voltage"}, 32'(f_bv), 32'(exp_bv));
    checkOutput({tag, "_valid"}, 32'(f_valid), 1);
    @(negedge clk);
    checkOutput({tag, "_pulse_width"}, 32'(f_new), 0);
    checkOutput({tag, "_voltage_hold"}, 32'(f_bv), 32'(exp_bv));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cyc, low, pulses, high, falls, rises;
    logic prev;

    rst_d = 1'b1; rst_f = 1'b1;
    d_miso = 1'b0; f_miso = 1'b0;
    f_code = '0; f_pre = '0; f_post = 1'b0; f_alt_mode = 0; f_alt = 0;
    f_word = '0; f_bit = 0;
    repeat (3) @(negedge clk);

    checkOutput("reset_cs_n", 32'(d_cs_n), 1);
    checkOutput("reset_sclk", 32'(d_sclk), 0);
    checkOutput("reset_voltage", 32'(d_bv), 0);
    checkOutput("reset_valid", 32'(d_valid), 0);
    checkOutput("reset_new_value", 32'(d_new), 0);
    checkOutput("reset_fast_cs_n", 32'(f_cs_n), 1);
    checkOutput("reset_fast_voltage", 32'(f_bv), 0);

    // Default instance: first start tick and one frame's shape.
    rst_d = 1'b0;
    cyc = 13000;
    for (int i = 1; i <= 13000; i++) begin
      @(negedge clk);
      if (d_cs_n === 1'b0) begin
        cyc = i;
        break;
      end
    end
    checkOutput("first_tick_cycles", 32'(cyc), 12000);

    low = 1; pulses = 0; high = 0; prev = d_sclk;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d_cs_n !== 1'b0) break;
      low++;
      if (d_sclk && !prev) pulses++;
      if (d_sclk) high++;
      prev = d_sclk;
    end
    checkOutput("default_cs_low_time", 32'(low), 198);
    checkOutput("default_sclk_pulses", 32'(pulses), 16);
    checkOutput("default_sclk_high_total", 32'(high), 96);
    checkOutput("default_no_early_publish", 32'(d_valid), 0);
    checkOutput("default_voltage_still_zero", 32'(d_bv), 0);

    // Fast instance: averaging and scaling.
    applyStimulus(12'h800, 0, 3'b000, 1'b0);
    runCase("const_800", 16'd16500);

    applyStimulus(12'h000, 1, 3'b000, 1'b0);
    runCase("alternating", 16'd16491);

    applyStimulus(12'hFFF, 0, 3'b000, 1'b0);
    runCase("const_fff", 16'd32991);

    // Reset at SCLK edge 7 of frame 10 of the following set.
    falls = (f_cs_n === 1'b0) ? 1 : 0;
    prev = f_cs_n;
    for (int i = 0; i < 5000 && falls < 10; i++) begin
      @(negedge clk);
      if (prev && !f_cs_n) falls++;
      prev = f_cs_n;
    end
    rises = 0;
    prev = f_sclk;
    for (int i = 0; i < 400 && rises < 8; i++) begin
      @(negedge clk);
      if (!prev && f_sclk) rises++;
      prev = f_sclk;
    end
    checkOutput("midreset_reached_edge7", 32'(rises), 8);
    checkOutput("midreset_in_frame", 32'(f_cs_n), 0);
    checkOutput("midreset_held_voltage", 32'(f_bv), 32991);
    checkOutput("midreset_held_valid", 32'(f_valid), 1);
    rst_f = 1'b1;
    f_code = 12'h800;
    @(negedge clk);
    checkOutput("midreset_cs_n", 32'(f_cs_n), 1);
    checkOutput("midreset_sclk", 32'(f_sclk), 0);
    checkOutput("midreset_voltage", 32'(f_bv), 0);
    checkOutput("midreset_valid", 32'(f_valid), 0);
    checkOutput("midreset_new_value", 32'(f_new), 0);
    rst_f = 1'b0;
    runCase("after_midreset", 16'd16500);

    applyStimulus(12'h000, 0, 3'b111, 1'b1);
    runCase("discard_bits", 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/battery_voltage_sampler.md
# battery_voltage_sampler

Periodically reads the battery-sense ADC over a 3-wire SPI link, averages 2^AVG_LOG2 conversions, and scales the averaged code to millivolts. Sits directly upstream of the global control peripheral and drives its `battery_voltage` input, which is exposed as global register 1.

## Interface
- `CLK_DIV`, 6: system clocks per SCLK half-period; minimum 3. The default gives a 1 MHz SCLK.
- `SAMPLE_PERIOD`, 12000: system clocks between conversion starts (default 1 kHz).
- `AVG_LOG2`, 4: log2 of the number of samples averaged; range 0–4.
- `SCALE_MV`, 33000: battery millivolts corresponding to ADC code 4096; at most 65535.
- `clk_12MHz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `adc_miso`  in  1  ADC serial data, asynchronous.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  SPI clock, mode 0 (idles low).
- `battery_voltage`  out  16  averaged battery voltage in mV.
- `voltage_valid`  out  1  high once the first full average has been published.
- `new_value`  out  1  one-cycle pulse on each `battery_voltage` update.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `battery_voltage`=0, `voltage_valid`=0, `new_value`=0. Reset also clears the accumulator, the sample count and the period counter.
- Period counter: free-running, wraps every SAMPLE_PERIOD cycles. Each wrap issues a start tick.
  - If the frame FSM is IDLE, the tick starts a frame.
  - If the FSM is busy, the tick is dropped and not queued.
- `adc_miso` passes through a 2-FF synchronizer. The FSM uses only the synchronized value.
- Frame FSM states:
  - IDLE → SETUP on start tick; `adc_cs_n` falls.
  - SETUP → SHIFT after CLK_DIV cycles.
  - SHIFT: 16 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
  - SHIFT → DONE at the end of the 16th low half; `adc_cs_n` rises.
  - DONE → IDLE after one cycle, during which the sample is accumulated.
- Bit capture: the synchronized MISO is sampled in the cycle where SCLK goes high. Rising edges are indexed 0–15.
  - Edges 0–2 carry sample time plus null bit and are discarded.
  - Edges 3–14 carry code[11:0], MSB first.
  - Edge 15 is discarded.
- Accumulation:
  - The accumulator is 16 bits (12+AVG_LOG2, zero-extended); the sample count is AVG_LOG2 bits.
  - On the conversion that completes the set, avg = (acc + code) >> AVG_LOG2, truncated. The accumulator and count then clear.
  - Scale stage: `battery_voltage` = (avg × SCALE_MV) >> 12. Use a 28-bit product, keep bits [27:12]; no saturation is needed. Set `new_value`=1 and `voltage_valid`=1.
- `voltage_valid` stays high until reset.

## Timing
- `adc_cs_n` low time per frame is exactly 33×CLK_DIV cycles (198 at default).
- First SCLK rise occurs CLK_DIV cycles after `adc_cs_n` falls. Final SCLK fall occurs CLK_DIV cycles before `adc_cs_n` rises.
- First start tick: SAMPLE_PERIOD cycles after `reset` deasserts.
- Output latency: `battery_voltage` and `new_value` update 2 cycles after the `adc_cs_n` rise of the completing frame (DONE cycle, then the scale register).
- `new_value` is exactly one cycle wide.
- `battery_voltage` holds its value between updates.
- Reset mid-frame: `adc_cs_n`=1 and `adc_sclk`=0 on the cycle after reset is sampled; the partial frame is discarded.
- Start tick in the same cycle as reset: reset wins.

## Structure
- Shared package holds the following constants:
  - ADC_FRAME_BITS=16
  - ADC_DATA_FIRST_EDGE=3
  - ADC_DATA_BITS=12
  - SCALE_SHIFT=12
  - FSM state encoding (IDLE, SETUP, SHIFT, DONE)
- One sub-module, `adc_frame_reader`, contains the SPI FSM, the synchronizer and the shifter.
  - Interface: `start`, `busy`, `code[11:0]`, `code_valid` pulse.
- The top level keeps the period counter, the accumulator and the scaling stage.

## Test plan
- Frame shape (ADC model):
  - Stimulus: default parameters.
  - Required: `adc_cs_n` low for 198 cycles; 16 SCLK pulses, each 6 cycles high and 6 low; first tick at cycle 12000 after reset.
- Constant code:
  - Stimulus: model returns code 0x800 for 16 frames.
  - Required: `battery_voltage`=16500; one `new_value` pulse; `voltage_valid` rises with it, 2 cycles after the 16th `adc_cs_n` rise.
- Alternating codes:
  - Stimulus: model alternates 0x000 / 0xFFF.
  - Required: avg=2047, `battery_voltage`=16491.
  - Stimulus: model returns constant 0xFFF.
  - Required: `battery_voltage`=32991.
- Discarded bits:
  - Stimulus: model drives 1 on edges 0–2 and 15, data 0x000.
  - Required: `battery_voltage`=0.
- Reset mid-frame:
  - Stimulus: assert `reset` at SCLK edge 7 of frame 10.
  - Required: next cycle `adc_cs_n`=1, `adc_sclk`=0, outputs 0. The following average again needs 16 full frames.
- Dropped tick:
  - Stimulus: SAMPLE_PERIOD=100, CLK_DIV=6 (frame longer than period).
  - Required: ticks arriving while busy are ignored; frames never overlap; no frame is shorter than 198 cycles.
